// File: rtl/pe_acc_collector.sv
// pe_acc_collector: sums ACC_LEN PE results per word into a FWFT output FIFO; ACC_SAT_EN enables saturating adds.
module pe_acc_collector #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 1,
  parameter int ACC_LEN      = 3,
  parameter int ACC_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 4,
  localparam int RW = DATA_WIDTH + WEIGHT_WIDTH + 1,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [RW-1:0]        in_result,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [AW:0]          fifo_count,
  output logic                 sat_flag
);
  localparam int CW = ACC_LEN > 1 ? $clog2(ACC_LEN) : 1;
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;
  state_t state, state_d;
  logic [ACC_WIDTH-1:0] acc, hold, sum, push_data;
  logic [ACC_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0] cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic beat, last, pop, push, space, sat_hit;
  assign in_ready  = state == ACCUM;
  assign busy      = state != IDLE;
  assign beat      = in_valid && in_ready;
  assign last      = cnt == CW'(ACC_LEN - 1);
  assign out_valid = fifo_count != '0;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid && out_ready;
  assign space     = fifo_count != (AW+1)'(FIFO_DEPTH) || pop;
`ifdef ACC_SAT_EN
  logic [ACC_WIDTH:0] sum_ext;
  assign sum_ext = {1'b0, acc} + (ACC_WIDTH+1)'(in_result);
  assign sat_hit = sum_ext[ACC_WIDTH];
  assign sum     = sat_hit ? '1 : sum_ext[ACC_WIDTH-1:0];
  always_ff @(posedge clk)
    if (rst) sat_flag <= 1'b0;
    else if (!clear && state == IDLE && start) sat_flag <= 1'b0;
    else if (!clear && beat && sat_hit) sat_flag <= 1'b1;
`else
  assign sat_hit  = 1'b0;
  assign sum      = acc + ACC_WIDTH'(in_result);
  assign sat_flag = sat_hit;
`endif
  always_comb begin
    state_d   = state;
    push      = 1'b0;
    push_data = sum;
    if (clear) state_d = IDLE;
    else case (state)
      IDLE:  state_d = start ? ACCUM : IDLE;
      ACCUM: if (beat && last) begin
        push    = space;
        state_d = space ? ACCUM : FLUSH;
      end
      default: begin
        push_data = hold;
        push      = space;
        state_d   = space ? ACCUM : FLUSH;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      hold       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state <= state_d;
      if (clear || (state == IDLE && start)) begin
        acc <= '0;
        cnt <= '0;
      end else if (beat) begin
        acc <= last ? '0 : sum;
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (!clear && beat && last && !space) hold <= sum;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: tb/tb_pe_acc_collector.sv
// tb_pe_acc_collector: directed self-checking bench for pe_acc_collector (ACC_WIDTH=10).
module tb_pe_acc_collector;
  logic clk = 0, rst = 1, start = 0, clear = 0, in_valid = 0, out_ready = 0;
  logic [9:0] in_result = '0;
  logic in_ready, out_valid, busy, sat_flag;
  logic [9:0] out_data;
  logic [2:0] fifo_count;
  int passed = 0, total = 0;
  pe_acc_collector #(.ACC_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .in_valid(in_valid),
    .in_result(in_result), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .fifo_count(fifo_count), .sat_flag(sat_flag)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic send(input int v);
    in_valid  = 1;
    in_result = 10'(v);
    tick();
    in_valid  = 0;
  endtask
  task automatic group(input int a, input int b, input int c);
    send(a);
    send(b);
    send(c);
  endtask
  task automatic pop_chk(input string tag, input int exp);
    check(tag, out_data, exp);
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_data", out_data, 0);
    // basic group
    start = 1;
    tick();
    start = 0;
    check("t1_ready", in_ready, 1);
    check("t1_busy", busy, 1);
    group(5, 6, 7);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 18);
    check("t1_count", fifo_count, 1);
    pop_chk("t1_pop", 18);
    check("t1_empty", fifo_count, 0);
    // fill, overflow into FLUSH
    for (int g = 0; g < 5; g++) group(1, 1, g + 1);
    check("t2_count", fifo_count, 4);
    check("t2_flush_ready", in_ready, 0);
    check("t2_flush_busy", busy, 1);
    send(9);
    check("t2_drop_count", fifo_count, 4);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("t2_after_count", fifo_count, 4);
    check("t2_after_ready", in_ready, 1);
    pop_chk("t2_o1", 4);
    pop_chk("t2_o2", 5);
    pop_chk("t2_o3", 6);
    pop_chk("t2_o4", 7);
    check("t2_empty", out_valid, 0);
    // full FIFO, last beat concurrent with pop
    for (int g = 0; g < 4; g++) group(10 + g, 0, 0);
    send(2);
    send(3);
    out_ready = 1;
    send(4);
    out_ready = 0;
    check("t3_count", fifo_count, 4);
    check("t3_ready", in_ready, 1);
    pop_chk("t3_o1", 11);
    pop_chk("t3_o2", 12);
    pop_chk("t3_o3", 13);
    pop_chk("t3_o4", 9);
    // overflow of the accumulator
    group(511, 511, 511);
`ifdef ACC_SAT_EN
    check("t4_data", out_data, 1023);
    check("t4_sat", sat_flag, 1);
`else
    check("t4_data", out_data, 509);
    check("t4_sat", sat_flag, 0);
`endif
    pop_chk("t4_pop", out_valid ? out_data : 0);
    // clear abandons a partial group
    group(1, 1, 1);
    send(4);
    send(4);
    clear = 1;
    tick();
    clear = 0;
    check("t5_busy", busy, 0);
    check("t5_ready", in_ready, 0);
    check("t5_count", fifo_count, 1);
    check("t5_head", out_data, 3);
`ifdef ACC_SAT_EN
    check("t5_sat_kept", sat_flag, 1);
`endif
    start = 1;
    tick();
    start = 0;
    check("t5_sat_clr", sat_flag, 0);
    group(1, 2, 3);
    check("t5_count2", fifo_count, 2);
    pop_chk("t5_o1", 3);
    pop_chk("t5_o2", 6);
    // reset while FLUSH holds and FIFO full
    for (int g = 0; g < 5; g++) group(1, 1, 1);
    check("t6_flush", in_ready, 0);
    check("t6_full", fifo_count, 4);
    rst = 1;
    tick();
    check("t6_valid", out_valid, 0);
    check("t6_count", fifo_count, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", in_ready, 0);
    rst = 0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
